// File: rtl/dance_input_pkg.sv
// Shared constants for the dance-game key input stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dance_input_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEBOUNCE_MS      = 20;
    localparam int REPEAT_DELAY_MS  = 500;
    localparam int REPEAT_PERIOD_MS = 200;

    localparam int CYCLES_PER_MS       = CLK_HZ / 1000;
    localparam int DEF_DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;
    localparam int DEF_REPEAT_DELAY    = CYCLES_PER_MS * REPEAT_DELAY_MS;
    localparam int DEF_REPEAT_PERIOD   = CYCLES_PER_MS * REPEAT_PERIOD_MS;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop sync, debounce to a stable level, registered press pulse on 0->1.
// Latency: stable level flips DEBOUNCE_CYCLES+2 edges after the raw key settles.
// Backpressure: none; press is a fire-and-forget one-cycle strobe.
module key_debounce
    import dance_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic          settled;
    logic [CW-1:0] cnt;

    assign pressed = ~sync2;
    assign settled = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // Any return to the stable level restarts the qualification window.
            if (pressed == level) begin
                cnt <= '0;
            end else if (settled) begin
                level <= pressed;
                press <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Four active-low keys -> clean one-cycle press pulses, auto-repeat on left/right.
// Latency: press pulse DEBOUNCE_CYCLES+2 edges after key falls; repeats at DELAY then every PERIOD.
// Backpressure: none; pulses are single-cycle strobes, keys are independent.
module button_conditioner
    import dance_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic       btn_up,
    output logic       btn_down,
    output logic       btn_left,
    output logic       btn_right,
    output logic [3:0] btn_level
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    key_vec_t level;
    key_vec_t press;
    key_vec_t rpt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[i]),
            .level (level[i]),
            .press (press[i])
        );

        if (i >= KEY_LEFT && REPEAT_DELAY > 0) begin : g_rpt
            logic [RW-1:0] cnt;
            logic          periodic;
            logic          fire;
            logic          rpt_q;

            assign fire = periodic ? (cnt == RW'(REPEAT_PERIOD - 1))
                                   : (cnt == RW'(REPEAT_DELAY - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt      <= '0;
                    periodic <= 1'b0;
                    rpt_q    <= 1'b0;
                end else if (!level[i]) begin
                    cnt      <= '0;
                    periodic <= 1'b0;
                    rpt_q    <= 1'b0;
                end else if (fire) begin
                    cnt      <= '0;
                    periodic <= 1'b1;
                    rpt_q    <= 1'b1;
                end else begin
                    cnt   <= cnt + RW'(1);
                    rpt_q <= 1'b0;
                end
            end

            // A repeat landing on the same edge the key debounces released is dropped.
            assign rpt[i] = rpt_q & level[i];
        end else begin : g_norpt
            assign rpt[i] = 1'b0;
        end
    end

    // press and rpt are mutually exclusive: press needs level low before the edge, rpt needs it high.
    assign {btn_right, btn_left, btn_down, btn_up} = press | rpt;
    assign btn_level = level;

endmodule
